// File: rtl/tff_ctrl_pkg.sv
// Shared encodings for the T flip-flop counter sequencer.
// The state values and direction codes are common to the controller and the bench.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } tff_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops with synchronous reset and parallel load.
// Each cell inverts its state whenever its toggle input is high.
module tff_bank #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Load takes priority over toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= load_val;
        end else begin
            q_q <= q_q ^ t;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer that runs a T flip-flop bank as a synchronous up/down counter.
// It walks the bank from a start value to a terminal value and pulses done on arrival.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter bit          RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    tff_state_t       state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             done_q, done_d;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             tog_en;
    logic [WIDTH-1:0] t_bank;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term;
    logic             all_ones;
    logic             all_zeros;

    assign start_val = (dir_q == DIR_DOWN) ? limit_q : '0;
    assign term      = (dir_q == DIR_DOWN) ? '0 : limit_q;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down); built as a running AND.
    always_comb begin
        t_vec     = '0;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            t_vec[i]  = (dir_q == DIR_DOWN) ? all_zeros : all_ones;
            all_ones  = all_ones & count[i];
            all_zeros = all_zeros & ~count[i];
        end
        if (state_q != StRun) begin
            t_vec = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        limit_d  = limit_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_val = start_val;
        tog_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d  = StRun;
                    dir_d    = dir;
                    limit_d  = limit;
                    load     = 1'b1;
                    load_val = (dir == DIR_DOWN) ? limit : '0;
                end
            end
            StRun: begin
                // Terminal is checked before toggling, so the bank can never wrap.
                if (stop) begin
                    state_d = StIdle;
                end else if (count == term) begin
                    done_d = 1'b1;
                    if (RELOAD) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (pause) begin
                    state_d = StPause;
                end else begin
                    tog_en = 1'b1;
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dir_q   <= DIR_UP;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
            done_q  <= done_d;
        end
    end

    assign t_bank = t_vec & {WIDTH{tog_en}};

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .t       (t_bank),
        .q       (count)
    );

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl: a one-shot instance driven from a vector table and
// hand sequences, plus a reload instance sharing the same inputs.
module tb_tff_count_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, dir;
    logic [3:0] limit;
    logic [3:0] t_vec, count, r_t_vec, r_count;
    logic       busy, done, r_busy, r_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tff_count_ctrl #(.WIDTH(4), .RELOAD(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .dir(dir),
        .limit(limit), .t_vec(t_vec), .count(count), .busy(busy), .done(done)
    );

    tff_count_ctrl #(.WIDTH(4), .RELOAD(1'b1)) u_dut_rl (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .dir(dir),
        .limit(limit), .t_vec(r_t_vec), .count(r_count), .busy(r_busy), .done(r_done)
    );

    typedef struct {
        logic       start, stop, pause, dir;
        logic [3:0] limit;
        logic [3:0] count, t_vec;
        logic       busy, done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, sp, pa, d, input logic [3:0] lim,
                       input logic [3:0] c, t, input logic b, dn);
        vec_t v;
        v.start = st; v.stop = sp; v.pause = pa; v.dir = d; v.limit = lim;
        v.count = c; v.t_vec = t; v.busy = b; v.done = dn;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic st, sp, pa, d, input logic [3:0] lim);
        start = st; stop = sp; pause = pa; dir = d; limit = lim;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic check_main(input string name, input logic [3:0] c, t,
                              input logic b, dn);
        check({name, ".count"}, 32'(count), 32'(c));
        check({name, ".t_vec"}, 32'(t_vec), 32'(t));
        check({name, ".busy"},  32'(busy),  32'(b));
        check({name, ".done"},  32'(done),  32'(dn));
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        check_main("reset", 4'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;

        //   st sp pa dir lim    cnt   t_vec  busy done
        add(1, 0, 0, 0, 4'h5,  4'h0, 4'h1, 1, 0);  // up one-shot to 5
        add(0, 0, 0, 0, 4'h0,  4'h1, 4'h3, 1, 0);
        add(1, 0, 0, 1, 4'hF,  4'h2, 4'h1, 1, 0);  // start/dir/limit ignored mid-run
        add(0, 0, 0, 0, 4'h0,  4'h3, 4'h7, 1, 0);
        add(0, 0, 0, 0, 4'h0,  4'h4, 4'h1, 1, 0);
        add(0, 0, 0, 0, 4'h0,  4'h5, 4'h3, 1, 0);
        add(0, 0, 0, 0, 4'h0,  4'h5, 4'h0, 0, 1);
        add(0, 0, 0, 0, 4'h0,  4'h5, 4'h0, 0, 0);
        add(1, 1, 0, 0, 4'h3,  4'h5, 4'h0, 0, 0);  // start with stop stays idle
        add(0, 0, 0, 0, 4'h0,  4'h5, 4'h0, 0, 0);
        add(1, 0, 0, 0, 4'h0,  4'h0, 4'h1, 1, 0);  // limit 0
        add(0, 0, 0, 0, 4'h0,  4'h0, 4'h0, 0, 1);
        add(1, 0, 0, 1, 4'h3,  4'h3, 4'h1, 1, 0);  // down from 3
        add(0, 0, 0, 0, 4'h0,  4'h2, 4'h3, 1, 0);
        add(0, 0, 0, 0, 4'h0,  4'h1, 4'h1, 1, 0);
        add(0, 0, 0, 0, 4'h0,  4'h0, 4'hF, 1, 0);
        add(0, 0, 0, 0, 4'h0,  4'h0, 4'h0, 0, 1);
        add(0, 0, 1, 0, 4'h0,  4'h0, 4'h0, 0, 0);  // pause in idle has no effect
        add(1, 0, 0, 1, 4'h1,  4'h1, 4'h1, 1, 0);  // terminal beats pause
        add(0, 0, 0, 0, 4'h0,  4'h0, 4'hF, 1, 0);
        add(0, 0, 1, 0, 4'h0,  4'h0, 4'h0, 0, 1);

        foreach (vq[i]) begin
            step(vq[i].start, vq[i].stop, vq[i].pause, vq[i].dir, vq[i].limit);
            check_main($sformatf("vec%0d", i), vq[i].count, vq[i].t_vec, vq[i].busy,
                       vq[i].done);
        end

        // Pause for two sampled cycles at count 4: done arrives three edges late.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check($sformatf("pause.pre%0d", i), 32'(count), 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
            check_main($sformatf("pause.hold%0d", i), 4'h4, 4'h0, 1'b1, 1'b0);
        end
        idle();
        check_main("pause.resume", 4'h4, 4'h1, 1'b1, 1'b0);
        for (int i = 5; i <= 9; i++) begin
            idle();
            check($sformatf("pause.post%0d", i), 32'(count), 32'(i));
            check($sformatf("pause.nodone%0d", i), 32'(done), 32'd0);
        end
        idle();
        check_main("pause.done", 4'h9, 4'h0, 1'b0, 1'b1);

        // Stop at count 6: no done pulse, count holds.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
        for (int i = 0; i < 6; i++) idle();
        check("stop.pre", 32'(count), 32'd6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        check_main("stop", 4'h6, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check_main($sformatf("stop.after%0d", i), 4'h6, 4'h0, 1'b0, 1'b0);
        end

        // Full down run from F with the 8 -> 7 carry.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
        check("down.load", 32'(count), 32'hF);
        for (int i = 1; i <= 15; i++) begin
            idle();
            check($sformatf("down.cnt%0d", i), 32'(count), 32'(15 - i));
            check($sformatf("down.done%0d", i), 32'(done), 32'd0);
            if (15 - i == 8) check("down.t_at_8", 32'(t_vec), 32'hF);
        end
        idle();
        check_main("down.done", 4'h0, 4'h0, 1'b0, 1'b1);

        // Full up run to F, no wrap.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
        check("up.load", 32'(count), 32'h0);
        for (int i = 1; i <= 15; i++) begin
            idle();
            check($sformatf("up.cnt%0d", i), 32'(count), 32'(i));
            if (i == 7) check("up.t_at_7", 32'(t_vec), 32'hF);
        end
        idle();
        check_main("up.done", 4'hF, 4'h0, 1'b0, 1'b1);
        idle();
        check_main("up.nowrap", 4'hF, 4'h0, 1'b0, 1'b0);

        // Reset held two cycles mid-run, even with start asserted.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
        for (int i = 0; i < 3; i++) idle();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
            check_main($sformatf("rst.mid%0d", i), 4'h0, 4'h0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        idle();
        check_main("rst.release", 4'h0, 4'h0, 1'b0, 1'b0);

        // Reload instance: up to 2, repeating with a done pulse on each reload.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
        check("rl.load", 32'(r_count), 32'h0);
        check("rl.busy", 32'(r_busy), 32'd1);
        for (int i = 0; i < 7; i++) begin
            idle();
            check($sformatf("rl.cnt%0d", i), 32'(r_count), 32'((i + 1) % 3));
            check($sformatf("rl.done%0d", i), 32'(r_done), 32'(i % 3 == 2));
            check($sformatf("rl.busy%0d", i), 32'(r_busy), 32'd1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("rl.stop.busy", 32'(r_busy), 32'd0);
        check("rl.stop.done", 32'(r_done), 32'd0);
        check("rl.stop.cnt", 32'(r_count), 32'd1);
        idle();
        check("rl.idle.cnt", 32'(r_count), 32'd1);
        check("rl.idle.done", 32'(r_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
